// File: rtl/i2cmb_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2cmb_txn_sequencer
// Brief    : Wishbone master that expands one I2C request into iicmb commands.
// Revision : 1.0 - initial release
// ============================================================================
module i2cmb_txn_sequencer #(
   parameter  int NUM_I2C_BUSSES = 1,
   parameter  int LEN_W          = 8,
   parameter  int TIMEOUT_CYC    = 1000000,
   localparam int BUS_W          = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_op_i,
   input  logic [6:0]       req_addr_i,
   input  logic [BUS_W-1:0] req_bus_i,
   input  logic [LEN_W-1:0] req_len_i,
   input  logic             wdata_valid_i,
   output logic             wdata_ready_o,
   input  logic [7:0]       wdata_i,
   output logic             rdata_valid_o,
   output logic [7:0]       rdata_o,
   output logic             done_o,
   output logic [1:0]       status_o,
   output logic             cyc_o,
   output logic             stb_o,
   output logic             we_o,
   output logic [1:0]       adr_o,
   output logic [7:0]       dat_o,
   input  logic [7:0]       dat_i,
   input  logic             ack_i,
   input  logic             irq_i
);

   localparam logic [1:0] c_ADR_CSR  = 2'd0;
   localparam logic [1:0] c_ADR_DPR  = 2'd1;
   localparam logic [1:0] c_ADR_CMDR = 2'd2;

   localparam logic [1:0] c_ST_OK  = 2'b00;
   localparam logic [1:0] c_ST_NAK = 2'b01;
   localparam logic [1:0] c_ST_AL  = 2'b10;
   localparam logic [1:0] c_ST_ERR = 2'b11;

   typedef enum logic [3:0] {
      S_INIT       = 4'd0,
      S_INIT_EN    = 4'd1,
      S_IDLE       = 4'd2,
      S_SETBUS_CMD = 4'd3,
      S_ADDR_CMD   = 4'd4,
      S_WR_GET     = 4'd5,
      S_WR_CMD     = 4'd6,
      S_RD_CMD     = 4'd7,
      S_RD_OUT     = 4'd8,
      S_STOP       = 4'd9,
      S_CMD_WAIT   = 4'd10,
      S_EVAL       = 4'd11,
      S_WB         = 4'd12,
      S_DONE       = 4'd13
   } state_t;

   typedef enum logic [2:0] {
      PH_SETBUS = 3'd0,
      PH_START  = 3'd1,
      PH_ADDR   = 3'd2,
      PH_WR     = 3'd3,
      PH_RD     = 3'd4,
      PH_STOP   = 3'd5
   } phase_t;

   state_t           r_state;
   state_t           r_ret;
   phase_t           r_phase;
   logic             r_op;
   logic [6:0]       r_addr;
   logic [BUS_W-1:0] r_bus;
   logic [LEN_W-1:0] r_cnt;
   logic [3:0]       r_flags;   // CMDR[7:4] = {DON, NAK, AL, ERR}
   logic [31:0]      r_tmo;
   logic             r_reinit;

   task automatic wb_go(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                        input state_t ret);
      cyc_o   <= 1'b1;
      stb_o   <= 1'b1;
      we_o    <= we;
      adr_o   <= adr;
      dat_o   <= dat;
      r_ret   <= ret;
      r_state <= S_WB;
   endtask

   task automatic issue_cmd(input logic [7:0] cmd, input phase_t ph);
      wb_go(1'b1, c_ADR_CMDR, cmd, S_CMD_WAIT);
      r_phase <= ph;
      r_tmo   <= '0;
   endtask

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state       <= S_INIT;
         r_ret         <= S_INIT;
         r_phase       <= PH_SETBUS;
         r_op          <= 1'b0;
         r_addr        <= '0;
         r_bus         <= '0;
         r_cnt         <= '0;
         r_flags       <= '0;
         r_tmo         <= '0;
         r_reinit      <= 1'b0;
         req_ready_o   <= 1'b0;
         wdata_ready_o <= 1'b0;
         rdata_valid_o <= 1'b0;
         rdata_o       <= '0;
         done_o        <= 1'b0;
         status_o      <= c_ST_OK;
         cyc_o         <= 1'b0;
         stb_o         <= 1'b0;
         we_o          <= 1'b0;
         adr_o         <= '0;
         dat_o         <= '0;
      end else begin
         rdata_valid_o <= 1'b0;
         done_o        <= 1'b0;
         case (r_state)
            S_INIT: begin
               if (r_reinit) begin
                  r_reinit <= 1'b0;
                  wb_go(1'b1, c_ADR_CSR, 8'h00, S_INIT_EN);
               end else begin
                  wb_go(1'b1, c_ADR_CSR, 8'hC0, S_IDLE);
               end
            end
            S_INIT_EN: wb_go(1'b1, c_ADR_CSR, 8'hC0, S_IDLE);
            S_IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  req_ready_o <= 1'b0;
                  r_op        <= req_op_i;
                  r_addr      <= req_addr_i;
                  r_bus       <= req_bus_i;
                  r_cnt       <= req_len_i;
                  status_o    <= c_ST_OK;
                  wb_go(1'b1, c_ADR_DPR, 8'(req_bus_i), S_SETBUS_CMD);
               end
            end
            S_SETBUS_CMD: issue_cmd(8'h06, PH_SETBUS);
            S_ADDR_CMD:   issue_cmd(8'h01, PH_ADDR);
            S_WR_GET: begin
               if (wdata_ready_o && wdata_valid_i) begin
                  wdata_ready_o <= 1'b0;
                  wb_go(1'b1, c_ADR_DPR, wdata_i, S_WR_CMD);
               end else begin
                  wdata_ready_o <= 1'b1;
               end
            end
            S_WR_CMD: issue_cmd(8'h01, PH_WR);
            S_RD_CMD: issue_cmd((r_cnt == LEN_W'(1)) ? 8'h03 : 8'h02, PH_RD);
            S_RD_OUT: begin
               if (r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);
               r_state <= (r_cnt <= LEN_W'(1)) ? S_STOP : S_RD_CMD;
            end
            S_STOP: issue_cmd(8'h05, PH_STOP);
            S_WB: begin
               if (ack_i) begin
                  cyc_o   <= 1'b0;
                  stb_o   <= 1'b0;
                  we_o    <= 1'b0;
                  adr_o   <= '0;
                  dat_o   <= '0;
                  r_flags <= dat_i[7:4];
                  r_state <= r_ret;
                  if (r_ret == S_RD_OUT) begin
                     rdata_o       <= dat_i;
                     rdata_valid_o <= 1'b1;
                  end
                  if (r_ret == S_IDLE) req_ready_o <= 1'b1;
               end
            end
            S_CMD_WAIT: begin
               if (irq_i) begin
                  wb_go(1'b0, c_ADR_CMDR, 8'h00, S_EVAL);
               end else if (r_tmo == 32'(TIMEOUT_CYC)) begin
                  if (r_phase != PH_STOP || status_o == c_ST_OK) status_o <= c_ST_ERR;
                  r_reinit <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_tmo <= r_tmo + 32'd1;
               end
            end
            S_EVAL: begin
               // A failing STOP only reports if nothing went wrong earlier.
               if (r_phase == PH_STOP) begin
                  if (status_o == c_ST_OK) begin
                     if (r_flags[1])       status_o <= c_ST_AL;
                     else if (r_flags[0])  status_o <= c_ST_ERR;
                     else if (r_flags[2])  status_o <= c_ST_NAK;
                     else if (!r_flags[3]) status_o <= c_ST_ERR;
                  end
                  r_state <= S_DONE;
               end else if (r_flags[1]) begin
                  status_o <= c_ST_AL;
                  r_state  <= S_DONE;
               end else if (r_flags[0] || (!r_flags[3] && !r_flags[2])) begin
                  status_o <= c_ST_ERR;
                  r_state  <= S_DONE;
               end else if (r_flags[2]) begin
                  status_o <= c_ST_NAK;
                  r_state  <= S_STOP;
               end else begin
                  case (r_phase)
                     PH_SETBUS: issue_cmd(8'h04, PH_START);
                     PH_START:  wb_go(1'b1, c_ADR_DPR, {r_addr, r_op}, S_ADDR_CMD);
                     PH_ADDR: begin
                        if (r_cnt == '0) r_state <= S_STOP;
                        else if (r_op)   r_state <= S_RD_CMD;
                        else             r_state <= S_WR_GET;
                     end
                     PH_WR: begin
                        if (r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);
                        r_state <= (r_cnt <= LEN_W'(1)) ? S_STOP : S_WR_GET;
                     end
                     PH_RD:     wb_go(1'b0, c_ADR_DPR, 8'h00, S_RD_OUT);
                     default:   r_state <= S_DONE;
                  endcase
               end
            end
            S_DONE: begin
               done_o <= 1'b1;
               if (r_reinit) begin
                  r_state <= S_INIT;
               end else begin
                  r_state     <= S_IDLE;
                  req_ready_o <= 1'b1;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2cmb_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2cmb_txn_sequencer
// Brief    : Directed bench with a small iicmb register/irq responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2cmb_txn_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, req_ready, req_op = 1'b0;
   logic [6:0] req_addr = '0;
   logic [0:0] req_bus = '0;
   logic [7:0] req_len = '0;
   logic       wdata_valid = 1'b0, wdata_ready;
   logic [7:0] wdata = '0;
   logic       rdata_valid, done;
   logic [7:0] rdata;
   logic [1:0] status;
   logic       cyc, stb, we;
   logic [1:0] adr;
   logic [7:0] dat_o, dat_i = '0;
   logic       ack = 1'b0, irq = 1'b0;

   int vectors = 0, miscompares = 0;

   i2cmb_txn_sequencer #(.NUM_I2C_BUSSES(1), .LEN_W(8), .TIMEOUT_CYC(50)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_addr_i(req_addr), .req_bus_i(req_bus), .req_len_i(req_len),
      .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
      .rdata_valid_o(rdata_valid), .rdata_o(rdata), .done_o(done), .status_o(status),
      .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i),
      .ack_i(ack), .irq_i(irq)
   );

   always #5 clk = ~clk;

   // Responder state
   logic [9:0] wlog[$];      // {adr, dat} of every Wishbone write
   logic [9:0] exp_w[$];
   logic [7:0] rq[$];        // bytes seen on rdata_o
   logic [7:0] wq[$];        // bytes offered on the write-data port
   logic [7:0] last_cmd = '0;
   logic [7:0] rd_next = 8'd100;
   int         irq_dly = 0;
   int         cyc_cnt = 0, t_cmd = 0, t_done = 0;
   int         done_cnt = 0, overlap = 0;
   logic [1:0] last_status = '0;
   bit         wready_seen = 0, suppress = 0, nak_addr = 0, al_start = 0;

   function automatic logic [7:0] cmd_resp(input logic [7:0] c);
      if (al_start && c == 8'h04) return 8'h20;
      if (nak_addr && c == 8'h01) return 8'h40;
      return 8'h80;
   endfunction

   always @(posedge clk) begin
      cyc_cnt = cyc_cnt + 1;
      if (!rst_n) begin
         ack     <= 1'b0;
         irq     <= 1'b0;
         irq_dly = 0;
      end else begin
         if (irq_dly > 0) begin
            irq_dly = irq_dly - 1;
            if (irq_dly == 0) irq <= 1'b1;
         end
         if (cyc && stb && !ack) begin
            ack <= 1'b1;
            if (we) begin
               wlog.push_back({adr, dat_o});
               if (adr == 2'd2) begin
                  last_cmd = dat_o;
                  t_cmd    = cyc_cnt;
                  if (!suppress) irq_dly = 3;
               end
            end else if (adr == 2'd2) begin
               irq   <= 1'b0;
               dat_i <= cmd_resp(last_cmd);
            end else if (adr == 2'd1) begin
               dat_i   <= rd_next;
               rd_next = rd_next + 8'd1;
            end else begin
               dat_i <= 8'h00;
            end
         end else begin
            ack <= 1'b0;
         end
         if (wdata_valid && wdata_ready && wq.size() > 0) void'(wq.pop_front());
      end
   end

   always @(negedge clk) begin
      wdata_valid = (wq.size() > 0);
      wdata       = (wq.size() > 0) ? wq[0] : 8'h00;
      if (done) begin
         done_cnt    = done_cnt + 1;
         last_status = status;
         t_done      = cyc_cnt;
      end
      if (rdata_valid) rq.push_back(rdata);
      if (done && rdata_valid) overlap = overlap + 1;
      if (wdata_ready) wready_seen = 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors = vectors + 1;
      assert (obs === expv) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_wlog(input string tag);
      check({tag, "_count"}, wlog.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
         check($sformatf("%s_w%0d", tag, i), 32'(wlog[i]), 32'(exp_w[i]));
   endtask

   task automatic wait_ready(input string tag, input int max);
      for (int i = 0; i < max && !req_ready; i++) @(negedge clk);
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int max);
      int start;
      start = done_cnt;
      for (int i = 0; i < max && done_cnt == start; i++) @(negedge clk);
      check({tag, "_done"}, 32'(done_cnt - start), 32'd1);
   endtask

   task automatic do_req(input string tag, input logic op, input logic [6:0] a,
                         input logic [7:0] len);
      wait_ready(tag, 200);
      wlog.delete();
      req_op = op; req_addr = a; req_bus = '0; req_len = len; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, "_taken"}, 32'(req_ready), 32'd0);
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_cyc", 32'(cyc), 0);
      check("rst_stb", 32'(stb), 0);
      check("rst_we", 32'(we), 0);
      check("rst_adr_dat", {22'd0, adr, dat_o}, 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_wready", 32'(wdata_ready), 0);
      check("rst_outs", {28'd0, done, rdata_valid, status}, 0);
      check("rst_rdata", 32'(rdata), 0);
      rst_n = 1'b1;

      // Enable after reset
      wait_ready("init", 50);
      exp_w = '{10'h0C0};
      check_wlog("init");

      // Write 3 bytes
      wq = '{8'h00, 8'h01, 8'h02};
      do_req("wr", 1'b0, 7'h22, 8'd3);
      wait_done("wr", 500);
      exp_w = '{10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h100, 10'h201,
                10'h101, 10'h201, 10'h102, 10'h201, 10'h205};
      check_wlog("wr");
      check("wr_status", 32'(last_status), 0);
      check("wr_bytes_left", wq.size(), 0);

      // Read 4 bytes
      rd_next = 8'd100;
      rq.delete();
      do_req("rd", 1'b1, 7'h22, 8'd4);
      wait_done("rd", 500);
      exp_w = '{10'h100, 10'h206, 10'h204, 10'h145, 10'h201, 10'h202, 10'h202,
                10'h202, 10'h203, 10'h205};
      check_wlog("rd");
      check("rd_status", 32'(last_status), 0);
      check("rd_count", rq.size(), 4);
      for (int i = 0; i < 4 && i < rq.size(); i++)
         check($sformatf("rd_byte%0d", i), 32'(rq[i]), 100 + i);

      // Address NAK on a write
      nak_addr = 1; wready_seen = 0;
      wq = '{8'hAA, 8'hBB};
      do_req("nak", 1'b0, 7'h22, 8'd2);
      wait_done("nak", 500);
      exp_w = '{10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h205};
      check_wlog("nak");
      check("nak_status", 32'(last_status), 32'd1);
      check("nak_wready", 32'(wready_seen), 0);
      check("nak_bytes_kept", wq.size(), 2);
      wq.delete(); nak_addr = 0;

      // Arbitration lost after START
      al_start = 1;
      do_req("al", 1'b0, 7'h22, 8'd1);
      wait_done("al", 500);
      exp_w = '{10'h100, 10'h206, 10'h204};
      check_wlog("al");
      check("al_status", 32'(last_status), 32'd2);
      wlog.delete();
      wait_ready("al_idle", 20);
      check("al_no_reinit", wlog.size(), 0);
      al_start = 0;

      // Irq timeout, then re-initialisation
      suppress = 1;
      do_req("tmo", 1'b0, 7'h22, 8'd1);
      wait_done("tmo", 300);
      wlog.delete();
      check("tmo_status", 32'(last_status), 32'd3);
      check("tmo_latency", 32'((t_done - t_cmd) >= 48 && (t_done - t_cmd) <= 58), 32'd1);
      suppress = 0;
      wait_ready("tmo_reinit", 50);
      exp_w = '{10'h000, 10'h0C0};
      check_wlog("tmo_reinit");

      // Address-only probe
      do_req("probe", 1'b0, 7'h22, 8'd0);
      wait_done("probe", 500);
      exp_w = '{10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h205};
      check_wlog("probe");
      check("probe_status", 32'(last_status), 0);

      // Reset during a read byte
      rq.delete();
      do_req("mrst", 1'b1, 7'h22, 8'd3);
      for (int i = 0; i < 500 && rq.size() == 0; i++) @(negedge clk);
      for (int i = 0; i < 100 && !(stb && adr == 2'd2); i++) @(negedge clk);
      check("mrst_stb_seen", 32'(stb && adr == 2'd2), 32'd1);
      begin
         int dc;
         dc = done_cnt;
         rst_n = 1'b0;
         @(negedge clk);
         check("mrst_cyc", 32'(cyc), 0);
         check("mrst_stb", 32'(stb), 0);
         @(negedge clk);
         wlog.delete();
         rst_n = 1'b1;
         wait_ready("mrst_init", 50);
         exp_w = '{10'h0C0};
         check_wlog("mrst_init");
         check("mrst_no_done", done_cnt - dc, 0);
      end

      check("no_overlap", overlap, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
